// File: rtl/instr_sequencer.sv
// instr_sequencer
// Control sequencer for the single-bus datapath. A start request in IDLE runs
// the fetch cycles T0..T2 and then the execute cycles for a register ALU
// instruction (unary, binary, or wide MUL/DIV with HI/LO result halves).
// Every output is a register, so nothing combinational reaches the outputs
// from start or mem_ready.
//
// Ports:
//   clk        rising-edge system clock
//   clear      synchronous active-high reset; forces IDLE, all outputs 0
//   start      request one instruction (sampled only in IDLE)
//   mem_ready  memory read data valid on Mdatain
//   ir         current IR contents from the datapath
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the final cycle of an instruction
//   illegal    one-cycle pulse (with done) on an unsupported opcode
//   PCout .. LOin  single-bit datapath enables
//   alu_op     ALU operation, nonzero only in the ALU-issue cycle
//   reg_in     one-hot register write enables
//   reg_out    one-hot register bus drives
module instr_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4,
  parameter int OP_W     = 5
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic                HIin,
  output logic                LOin,
  output logic [OP_W-1:0]     alu_op,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out
);

  localparam int OP_LSB = DATA_W - OP_W;
  localparam int RA_LSB = OP_LSB - REG_W;
  localparam int RB_LSB = RA_LSB - REG_W;
  localparam int RC_LSB = RB_LSB - REG_W;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_ROR = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_ROL = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(5'b10001);
  localparam logic [OP_W-1:0] OP_NEG = OP_W'(5'b10010);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  typedef enum logic [1:0] {
    CLS_ILLEGAL, CLS_UNARY, CLS_BINARY, CLS_WIDE
  } op_class_t;

  state_t          state;
  op_class_t       cls_q;
  logic [OP_W-1:0] op_q;
  logic [REG_W-1:0] ra_q;
  logic [REG_W-1:0] rc_q;

  logic [OP_W-1:0]  ir_op;
  logic [REG_W-1:0] ir_ra;
  logic [REG_W-1:0] ir_rb;
  logic [REG_W-1:0] ir_rc;
  logic             ir_unused;

  assign ir_op     = ir[OP_LSB +: OP_W];
  assign ir_ra     = ir[RA_LSB +: REG_W];
  assign ir_rb     = ir[RB_LSB +: REG_W];
  assign ir_rc     = ir[RC_LSB +: REG_W];
  assign ir_unused = ^ir[RC_LSB-1:0];

  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    op_class_t c;
    case (op)
      OP_NOT, OP_NEG:                          c = CLS_UNARY;
      OP_MUL, OP_DIV:                          c = CLS_WIDE;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:           c = CLS_BINARY;
      default:                                 c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  // Indices at or beyond NUM_REGS match no bit, giving an all-zero select.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [REG_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == REG_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Each branch picks the next state and loads the outputs that state must
  // present, so outputs change exactly when the state does. Anything not
  // set falls back to 0. The illegal decision is made on the edge into T2
  // (from ir) so the pulse can be registered and still appear during T2.
  always_ff @(posedge clk) begin
    busy     <= 1'b0;
    done     <= 1'b0;
    illegal  <= 1'b0;
    PCout    <= 1'b0;
    Zlowout  <= 1'b0;
    Zhighout <= 1'b0;
    MDRout   <= 1'b0;
    MARin    <= 1'b0;
    Zin      <= 1'b0;
    PCin     <= 1'b0;
    MDRin    <= 1'b0;
    IRin     <= 1'b0;
    Yin      <= 1'b0;
    IncPC    <= 1'b0;
    Read     <= 1'b0;
    HIin     <= 1'b0;
    LOin     <= 1'b0;
    alu_op   <= '0;
    reg_in   <= '0;
    reg_out  <= '0;
    if (clear) begin
      state <= S_IDLE;
      cls_q <= CLS_ILLEGAL;
      op_q  <= '0;
      ra_q  <= '0;
      rc_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_T0;
            busy  <= 1'b1;
            PCout <= 1'b1;
            MARin <= 1'b1;
            IncPC <= 1'b1;
            Zin   <= 1'b1;
          end
        end
        S_T0: begin
          state   <= S_T1;
          busy    <= 1'b1;
          Zlowout <= 1'b1;
          PCin    <= 1'b1;
          Read    <= 1'b1;
          MDRin   <= 1'b1;
        end
        S_T1: begin
          busy <= 1'b1;
          if (!mem_ready) begin
            Zlowout <= 1'b1;
            PCin    <= 1'b1;
            Read    <= 1'b1;
            MDRin   <= 1'b1;
          end else begin
            state  <= S_T2;
            MDRout <= 1'b1;
            IRin   <= 1'b1;
            if (classify(ir_op) == CLS_ILLEGAL) begin
              illegal <= 1'b1;
              done    <= 1'b1;
            end
          end
        end
        S_T2: begin
          if (illegal) begin
            state <= S_IDLE;
          end else begin
            state   <= S_T3;
            busy    <= 1'b1;
            cls_q   <= classify(ir_op);
            op_q    <= ir_op;
            ra_q    <= ir_ra;
            rc_q    <= ir_rc;
            reg_out <= reg_sel(ir_rb);
            if (classify(ir_op) == CLS_UNARY) begin
              alu_op <= ir_op;
              Zin    <= 1'b1;
            end else begin
              Yin <= 1'b1;
            end
          end
        end
        S_T3: begin
          state <= S_T4;
          busy  <= 1'b1;
          if (cls_q == CLS_UNARY) begin
            Zlowout <= 1'b1;
            reg_in  <= reg_sel(ra_q);
            done    <= 1'b1;
          end else begin
            reg_out <= reg_sel(rc_q);
            alu_op  <= op_q;
            Zin     <= 1'b1;
          end
        end
        S_T4: begin
          if (cls_q == CLS_UNARY) begin
            state <= S_IDLE;
          end else begin
            state   <= S_T5;
            busy    <= 1'b1;
            Zlowout <= 1'b1;
            if (cls_q == CLS_WIDE) begin
              LOin <= 1'b1;
            end else begin
              reg_in <= reg_sel(ra_q);
              done   <= 1'b1;
            end
          end
        end
        S_T5: begin
          if (cls_q == CLS_WIDE) begin
            state    <= S_T6;
            busy     <= 1'b1;
            Zhighout <= 1'b1;
            HIin     <= 1'b1;
            done     <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
